config_bank_loader: RTL



---
 rtl/config_bank_loader_if.sv | 14 +
 rtl/config_bank_loader.sv | 113 +++++++++++
 2 files changed

// File: rtl/config_bank_loader_if.sv
// config_bank_loader_if: bitstream handshake and tile write bus of the config bank loader
interface config_bank_loader_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic bs_valid;
  logic bs_ready;
  logic [DATA_WIDTH-1:0] bs_data;
  logic enable;
  logic [0:ADDR_WIDTH-1] address;
  logic data_in;
  modport master (output bs_valid, bs_data, input bs_ready, enable, address, data_in);
  modport slave (input bs_valid, bs_data, output bs_ready, enable, address, data_in);
endinterface

// File: rtl/config_bank_loader.sv
// config_bank_loader: serialises bitstream words into single-bit configuration writes for one bank column
module config_bank_loader #(
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_BITS = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic prog_clk,
  input  logic prog_reset_n,
  input  logic start,
  input  logic abort,
  config_bank_loader_if.slave bus,
  output logic busy,
  output logic done,
  output logic error
);
  localparam int WW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_BIT = ADDR_WIDTH'(NUM_BITS - 1);
  localparam logic [WW-1:0] LAST_WORD = WW'(DATA_WIDTH - 1);
  typedef enum logic [2:0] {IDLE, LOAD, SETUP, STROBE, HOLD, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] bit_cnt_q, bit_cnt_d, address_q, address_d;
  logic [WW-1:0] word_idx_q, word_idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic data_in_q, data_in_d, enable_q, enable_d, ready_q, ready_d;
  logic busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic accept;
  assign bus.bs_ready = ready_q && !abort;
  assign bus.enable = enable_q;
  assign bus.address = address_q;
  assign bus.data_in = data_in_q;
  assign busy = busy_q;
  assign done = done_q;
  assign error = error_q;
  // Next state plus registered outputs derived from the state being entered; the last HOLD of a word already offers ready
  always_comb begin
    state_d = state_q;
    bit_cnt_d = bit_cnt_q;
    word_idx_d = word_idx_q;
    shift_d = shift_q;
    address_d = address_q;
    data_in_d = data_in_q;
    error_d = error_q;
    accept = bus.bs_valid && ready_q && !abort;
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      error_d = 1'b1;
    end else begin
      case (state_q)
        IDLE, DONE: if (start) begin
          state_d = LOAD;
          error_d = 1'b0;
          bit_cnt_d = '0;
        end
        LOAD: if (accept) begin
          shift_d = bus.bs_data;
          word_idx_d = '0;
          state_d = SETUP;
        end
        SETUP: state_d = STROBE;
        STROBE: state_d = HOLD;
        HOLD: if (bit_cnt_q == LAST_BIT) state_d = DONE;
        else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (word_idx_q != LAST_WORD) begin
            word_idx_d = word_idx_q + 1'b1;
            shift_d = shift_q << 1;
            state_d = SETUP;
          end else if (accept) begin
            shift_d = bus.bs_data;
            word_idx_d = '0;
            state_d = SETUP;
          end else state_d = LOAD;
        end
        default: state_d = IDLE;
      endcase
    end
    if (state_d == SETUP) begin
      address_d = bit_cnt_d;
      data_in_d = shift_d[DATA_WIDTH-1];
    end
    enable_d = state_d == STROBE;
    ready_d = state_d == LOAD || (state_d == HOLD && bit_cnt_d != LAST_BIT && word_idx_d == LAST_WORD);
    busy_d = state_d inside {LOAD, SETUP, STROBE, HOLD};
    done_d = state_d == DONE;
  end
  // State and output registers; reset drops the write strobe immediately
  always_ff @(posedge prog_clk or negedge prog_reset_n)
    if (!prog_reset_n) begin
      state_q <= IDLE;
      bit_cnt_q <= '0;
      word_idx_q <= '0;
      shift_q <= '0;
      address_q <= '0;
      data_in_q <= 1'b0;
      enable_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_cnt_q <= bit_cnt_d;
      word_idx_q <= word_idx_d;
      shift_q <= shift_d;
      address_q <= address_d;
      data_in_q <= data_in_d;
      enable_q <= enable_d;
      ready_q <= ready_d;
      busy_q <= busy_d;
      done_q <= done_d;
      error_q <= error_d;
    end
endmodule
